// File: rtl/alu_arb_pkg.sv
// Shared constants, request struct, FSM states and opcode legality for alu_arbiter.
package alu_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [3:0]        op;
    logic [2:0]        cmp;
  } alu_req_t;

  localparam alu_req_t ALU_REQ_RST = '{src1: '0, src2: '0, op: ALU_ADD, cmp: '0};

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_NAND: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus of alu_arbiter: master = requesters + response consumer, slave = arbiter.
interface alu_arbiter_if;
  import alu_arb_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_src1;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_src2;
  logic [NUM_REQ-1:0][3:0]        req_op;
  logic [NUM_REQ-1:0][2:0]        req_cmp;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_cout;
  logic              rsp_overflow;
  logic              rsp_err;

  modport master (
    output req_valid, req_src1, req_src2, req_op, req_cmp, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err
  );

  modport slave (
    input  req_valid, req_src1, req_src2, req_op, req_cmp, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer moves only on an accepted handshake.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  logic last;

  // On a tie, favour whoever was not granted last.
  always_comb begin
    grant = req;
    if (&req) grant = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= 1'b1;
    else if (accept) last <= grant[1];
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer for the shared ALU: accept -> EXEC -> held response.
// Optional illegal-opcode trapping under `define ALU_ARB_ERR_CHECK_EN.
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic              alu_rst_n,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [3:0]        alu_ctrl,
  output logic [2:0]        alu_bonus,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic              alu_overflow
);
  arb_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] grant;
  logic               idle_ok, accept, win_id, op_bad;
  alu_req_t           win_req, acc_req, op_q;
  logic               id_q, err_q;
  logic               rsp_id_q, rsp_zero_q, rsp_cout_q, rsp_ovf_q, rsp_err_q;
  logic [DATA_W-1:0]  rsp_result_q;

  // Gating with rst keeps req_ready low while reset is held even though state is IDLE.
  assign idle_ok       = (state == IDLE) && !rst;
  assign accept        = idle_ok && (|bus.req_valid);
  assign win_id        = grant[1];
  assign bus.req_ready = grant & {NUM_REQ{idle_ok}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (bus.req_valid),
    .accept(accept),
    .grant (grant)
  );

  assign win_req = '{src1: bus.req_src1[win_id], src2: bus.req_src2[win_id],
                     op:   bus.req_op[win_id],   cmp:  bus.req_cmp[win_id]};

`ifdef ALU_ARB_ERR_CHECK_EN
  assign op_bad = !is_legal_op(win_req.op);
`else
  assign op_bad = 1'b0;
`endif

  // An illegal op still runs the full sequence, but the ALU only sees a harmless ADD 0+0.
  assign acc_req = op_bad ? '{src1: '0, src2: '0, op: ALU_ADD, cmp: win_req.cmp} : win_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= ALU_REQ_RST;
      id_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      op_q  <= acc_req;
      id_q  <= win_id;
      err_q <= op_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id_q     <= id_q;
      rsp_result_q <= err_q ? '0 : alu_result;
      rsp_zero_q   <= !err_q && alu_zero;
      rsp_cout_q   <= !err_q && alu_cout;
      rsp_ovf_q    <= !err_q && alu_overflow;
      rsp_err_q    <= err_q;
    end
  end

  assign alu_rst_n = !rst;
  assign alu_src1  = op_q.src1;
  assign alu_src2  = op_q.src2;
  assign alu_ctrl  = op_q.op;
  assign alu_bonus = op_q.cmp;

  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_cout     = rsp_cout_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_err      = rsp_err_q;
endmodule
